dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port synchronous data RAM between the CPU data port (load/store path, decoded as memory rather than I/O by the control unit) and the UART program loader. It sits between the memory-or-I/O decode stage and the data RAM instance. It accepts at most one access per cycle and returns read data one cycle after grant, tagged to the requester that issued the read.

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data RAM between the CPU
// load/store path and the UART program loader (UPG). One access per cycle,
// zero-cycle grant, and read data returns one cycle after grant. The return
// is steered to the requester that issued the read.
//
// Build option: define DMEM_ARB_RR_EN to arbitrate contention round-robin
// using the last_grant register. Without it, the loader always wins
// contention and last_grant is only tracked.
module dmem_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,

   input  logic              upg_req,
   input  logic              upg_we,
   input  logic [ADDR_W-1:0] upg_addr,
   input  logic [DATA_W-1:0] upg_wdata,
   output logic              upg_gnt,
   output logic              upg_rvalid,
   output logic [DATA_W-1:0] upg_rdata,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              busy
);

   // Owner of the read currently in flight through the RAM.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_UPG  = 2'd2
   } owner_e;

   // Requester that received the most recent grant.
   typedef enum logic {
      LAST_CPU = 1'b0,
      LAST_UPG = 1'b1
   } last_e;

   owner_e            rdOwn_q, rdOwn_d;
   last_e             lastGrant_q, lastGrant_d;
   logic [DATA_W-1:0] cpuRdata_q, cpuRdata_d;
   logic [DATA_W-1:0] upgRdata_q, upgRdata_d;

   logic cpuWin;
   logic upgWin;
   logic contention;

   // Pick the single winner for this cycle. Reset forces no grant at all, so
   // nothing reaches the RAM while the system is being reset.
   always_comb begin
      cpuWin     = 1'b0;
      upgWin     = 1'b0;
      contention = 1'b0;
      if (!reset) begin
         contention = cpu_req && upg_req;
         if (contention) begin
`ifdef DMEM_ARB_RR_EN
            if (lastGrant_q == LAST_CPU) begin
               upgWin = 1'b1;
            end else begin
               cpuWin = 1'b1;
            end
`else
            upgWin = 1'b1;
`endif
         end else if (cpu_req) begin
            cpuWin = 1'b1;
         end else if (upg_req) begin
            upgWin = 1'b1;
         end
      end
   end

   // Grant strobes and contention flag follow the winner directly.
   always_comb begin
      cpu_gnt = cpuWin;
      upg_gnt = upgWin;
      busy    = contention;
   end

   // Steer the winner's command onto the RAM port. The bus is parked at zero
   // when nobody is granted so idle cycles are easy to spot on a trace.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpuWin) begin
         mem_en    = 1'b1;
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (upgWin) begin
         mem_en    = 1'b1;
         mem_we    = upg_we;
         mem_addr  = upg_addr;
         mem_wdata = upg_wdata;
      end
   end

   // Read return: the registered owner tag selects which port sees the RAM
   // data this cycle. The other port replays its held value. Reset hides an
   // in-flight return and shows zero data.
   always_comb begin
      cpu_rvalid = 1'b0;
      upg_rvalid = 1'b0;
      cpu_rdata  = '0;
      upg_rdata  = '0;
      if (!reset) begin
         cpu_rvalid = (rdOwn_q == OWN_CPU);
         upg_rvalid = (rdOwn_q == OWN_UPG);
         cpu_rdata  = cpu_rvalid ? mem_rdata : cpuRdata_q;
         upg_rdata  = upg_rvalid ? mem_rdata : upgRdata_q;
      end
   end

   // Next-state for the owner tag, last_grant and the held read data.
   always_comb begin
      rdOwn_d     = OWN_NONE;
      lastGrant_d = lastGrant_q;
      cpuRdata_d  = cpu_rdata;
      upgRdata_d  = upg_rdata;
      if (cpuWin) begin
         lastGrant_d = LAST_CPU;
         if (!cpu_we) begin
            rdOwn_d = OWN_CPU;
         end
      end else if (upgWin) begin
         lastGrant_d = LAST_UPG;
         if (!upg_we) begin
            rdOwn_d = OWN_UPG;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         rdOwn_q     <= OWN_NONE;
         lastGrant_q <= LAST_CPU;
         cpuRdata_q  <= '0;
         upgRdata_q  <= '0;
      end else begin
         rdOwn_q     <= rdOwn_d;
         lastGrant_q <= lastGrant_d;
         cpuRdata_q  <= cpuRdata_d;
         upgRdata_q  <= upgRdata_d;
      end
   end

   // Never grant both requesters in the same cycle.
   always_ff @(posedge clock) begin
      assert (!(cpu_gnt && upg_gnt))
         else $error("dmem_arbiter: both grants asserted");
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural synchronous RAM.
// It runs in either build. Define DMEM_ARB_RR_EN when compiling the design
// so that the contention expectations match the design.
module tb_dmem_arbiter;

   localparam int ADDR_W = 14;
   localparam int DATA_W = 32;

   logic              clock;
   logic              reset;
   logic              cpuReq, cpuWe, cpuGnt, cpuRvalid;
   logic [ADDR_W-1:0] cpuAddr;
   logic [DATA_W-1:0] cpuWdata, cpuRdata;
   logic              upgReq, upgWe, upgGnt, upgRvalid;
   logic [ADDR_W-1:0] upgAddr;
   logic [DATA_W-1:0] upgWdata, upgRdata;
   logic              memEn, memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata, memRdata;
   logic              busy;

   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   int nChecks;
   int nFail;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
      .cpu_gnt(cpuGnt), .cpu_rvalid(cpuRvalid), .cpu_rdata(cpuRdata),
      .upg_req(upgReq), .upg_we(upgWe), .upg_addr(upgAddr), .upg_wdata(upgWdata),
      .upg_gnt(upgGnt), .upg_rvalid(upgRvalid), .upg_rdata(upgRdata),
      .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
      .mem_rdata(memRdata), .busy(busy)
   );

   // 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single-port synchronous RAM model: data appears one cycle after a read
   always @(posedge clock) begin
      if (memEn) begin
         if (memWe) ram[memAddr] <= memWdata;
         else       memRdata     <= ram[memAddr];
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic cReq, input logic cWe, input logic [ADDR_W-1:0] cA,
                                input logic [DATA_W-1:0] cD, input logic uReq, input logic uWe,
                                input logic [ADDR_W-1:0] uA, input logic [DATA_W-1:0] uD);
      cpuReq = cReq; cpuWe = cWe; cpuAddr = cA; cpuWdata = cD;
      upgReq = uReq; upgWe = uWe; upgAddr = uA; upgWdata = uD;
      #1;
   endtask

   task automatic applyReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 14'h3, 32'h1, 1'b1, 1'b0, 14'h4, 32'h2);
      tick();
      nChecks++; if (cpuGnt !== 1'b0 || upgGnt !== 1'b0) begin nFail++; $display("[TB] FAIL reset_gnt: got %b%b expected 00", cpuGnt, upgGnt); end
      nChecks++; if (memEn !== 1'b0 || memWe !== 1'b0) begin nFail++; $display("[TB] FAIL reset_mem: got en=%b we=%b expected 0 0", memEn, memWe); end
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      nChecks++; if (cpuRvalid !== 1'b0 || upgRvalid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_rvalid: got %b%b expected 00", cpuRvalid, upgRvalid); end
      nChecks++; if (cpuRdata !== 32'h0 || upgRdata !== 32'h0) begin nFail++; $display("[TB] FAIL reset_rdata: got %h %h expected 0 0", cpuRdata, upgRdata); end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      reset = 1'b0;
      #1;
   endtask

   task automatic test_cpu_write();
      applyStimulus(1'b1, 1'b1, 14'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
      nChecks++; if (cpuGnt !== 1'b1 || upgGnt !== 1'b0) begin nFail++; $display("[TB] FAIL wr_gnt: got %b%b expected 10", cpuGnt, upgGnt); end
      nChecks++; if (memEn !== 1'b1 || memWe !== 1'b1) begin nFail++; $display("[TB] FAIL wr_mem_ctl: got en=%b we=%b expected 1 1", memEn, memWe); end
      nChecks++; if (memAddr !== 14'h010 || memWdata !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL wr_mem_bus: got %h %h expected 0010 deadbeef", memAddr, memWdata); end
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL wr_busy: got %b expected 0", busy); end
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      nChecks++; if (cpuRvalid !== 1'b0 || upgRvalid !== 1'b0) begin nFail++; $display("[TB] FAIL wr_no_rvalid: got %b%b expected 00", cpuRvalid, upgRvalid); end
   endtask

   task automatic test_cpu_read();
      applyStimulus(1'b1, 1'b0, 14'h010, 32'h0, 1'b0, 1'b0, '0, '0);
      nChecks++; if (cpuGnt !== 1'b1 || memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 14'h010) begin nFail++; $display("[TB] FAIL rd_issue: got gnt=%b en=%b we=%b addr=%h expected 1 1 0 0010", cpuGnt, memEn, memWe, memAddr); end
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      nChecks++; if (cpuRvalid !== 1'b1 || cpuRdata !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL rd_return: got v=%b d=%h expected 1 deadbeef", cpuRvalid, cpuRdata); end
      nChecks++; if (upgRvalid !== 1'b0 || upgRdata !== 32'h0) begin nFail++; $display("[TB] FAIL rd_other_port: got v=%b d=%h expected 0 0", upgRvalid, upgRdata); end
      tick();
      nChecks++; if (cpuRvalid !== 1'b0 || cpuRdata !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL rd_hold: got v=%b d=%h expected 0 deadbeef", cpuRvalid, cpuRdata); end
   endtask

   task automatic test_back_to_back();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'h001, '0);
      nChecks++; if (upgGnt !== 1'b1 || cpuGnt !== 1'b0 || memAddr !== 14'h001) begin nFail++; $display("[TB] FAIL b2b_upg_gnt: got %b%b addr=%h expected 01 0001", cpuGnt, upgGnt, memAddr); end
      tick();
      applyStimulus(1'b1, 1'b0, 14'h002, '0, 1'b0, 1'b0, '0, '0);
      nChecks++; if (upgRvalid !== 1'b1 || upgRdata !== 32'hA5000001 || cpuRvalid !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_upg_ret: got uv=%b ud=%h cv=%b expected 1 a5000001 0", upgRvalid, upgRdata, cpuRvalid); end
      nChecks++; if (cpuGnt !== 1'b1 || memAddr !== 14'h002) begin nFail++; $display("[TB] FAIL b2b_cpu_gnt: got %b addr=%h expected 1 0002", cpuGnt, memAddr); end
      tick();
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      nChecks++; if (cpuRvalid !== 1'b1 || cpuRdata !== 32'hA5000002 || upgRvalid !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_cpu_ret: got cv=%b cd=%h uv=%b expected 1 a5000002 0", cpuRvalid, cpuRdata, upgRvalid); end
      nChecks++; if (upgRdata !== 32'hA5000001) begin nFail++; $display("[TB] FAIL b2b_upg_hold: got %h expected a5000001", upgRdata); end
      tick();
   endtask

   task automatic test_contention();
      logic expUpg, prevUpg;
      applyReset();
      prevUpg = 1'b0;
      applyStimulus(1'b1, 1'b0, 14'h002, '0, 1'b1, 1'b0, 14'h001, '0);
      for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
         expUpg = (k % 2 == 0);
`else
         expUpg = 1'b1;
`endif
         if (k > 0) begin
            nChecks++; if (upgRvalid !== prevUpg || cpuRvalid !== !prevUpg) begin nFail++; $display("[TB] FAIL cont_ret%0d: got cv=%b uv=%b expected %b %b", k, cpuRvalid, upgRvalid, !prevUpg, prevUpg); end
         end
         nChecks++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL cont_busy%0d: got %b expected 1", k, busy); end
         nChecks++; if (upgGnt !== expUpg || cpuGnt !== !expUpg) begin nFail++; $display("[TB] FAIL cont_gnt%0d: got cpu=%b upg=%b expected %b %b", k, cpuGnt, upgGnt, !expUpg, expUpg); end
         nChecks++; if (memAddr !== (expUpg ? 14'h001 : 14'h002)) begin nFail++; $display("[TB] FAIL cont_addr%0d: got %h expected %h", k, memAddr, expUpg ? 14'h001 : 14'h002); end
         prevUpg = expUpg;
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      nChecks++; if (upgRvalid !== prevUpg || cpuRvalid !== !prevUpg) begin nFail++; $display("[TB] FAIL cont_ret_last: got cv=%b uv=%b expected %b %b", cpuRvalid, upgRvalid, !prevUpg, prevUpg); end
      nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL cont_busy_off: got %b expected 0", busy); end
      tick();
   endtask

   task automatic test_reset_mid_read();
      applyStimulus(1'b1, 1'b0, 14'h010, '0, 1'b0, 1'b0, '0, '0);
      nChecks++; if (cpuGnt !== 1'b1) begin nFail++; $display("[TB] FAIL rmr_gnt: got %b expected 1", cpuGnt); end
      tick();
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         nChecks++; if (cpuRvalid !== 1'b0 || cpuRdata !== 32'h0) begin nFail++; $display("[TB] FAIL rmr_ret%0d: got v=%b d=%h expected 0 0", k, cpuRvalid, cpuRdata); end
         nChecks++; if (cpuGnt !== 1'b0 || upgGnt !== 1'b0 || memEn !== 1'b0) begin nFail++; $display("[TB] FAIL rmr_gate%0d: got %b%b en=%b expected 00 0", k, cpuGnt, upgGnt, memEn); end
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      reset = 1'b0;
      #1;
      tick();
      nChecks++; if (cpuRvalid !== 1'b0 || cpuRdata !== 32'h0) begin nFail++; $display("[TB] FAIL rmr_after: got v=%b d=%h expected 0 0", cpuRvalid, cpuRdata); end
   endtask

   task automatic test_idle();
      applyStimulus(1'b1, 1'b0, 14'h010, '0, 1'b0, 1'b0, '0, '0);
      tick();
      applyStimulus(1'b0, 1'b0, 14'h3FF, 32'h12345678, 1'b0, 1'b1, 14'h155, 32'h87654321);
      for (int k = 0; k < 3; k++) begin
         tick();
         nChecks++; if (memEn !== 1'b0 || memWe !== 1'b0 || memAddr !== 14'h0 || memWdata !== 32'h0) begin nFail++; $display("[TB] FAIL idle_mem%0d: got en=%b we=%b a=%h d=%h expected 0 0 0 0", k, memEn, memWe, memAddr, memWdata); end
         nChecks++; if (cpuRvalid !== 1'b0 || upgRvalid !== 1'b0) begin nFail++; $display("[TB] FAIL idle_rvalid%0d: got %b%b expected 00", k, cpuRvalid, upgRvalid); end
         nChecks++; if (cpuRdata !== 32'hDEADBEEF || upgRdata !== 32'h0) begin nFail++; $display("[TB] FAIL idle_hold%0d: got %h %h expected deadbeef 0", k, cpuRdata, upgRdata); end
      end
   endtask

   task automatic checkOutput();
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
   endtask

   initial begin
      nChecks = 0;
      nFail   = 0;
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'hA5000000 | i;
      memRdata = '0;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_back_to_back();
      test_contention();
      test_reset_mid_read();
      test_idle();
      checkOutput();
      $finish;
   end

endmodule
